// File: rtl/sram_bridge_pkg.sv
// Shared FSM encoding, inactive-strobe levels and wait-counter width for sram_multiport_bridge.
// Optional feature macro used by the bridge: SRAM_ARB_ROUND_ROBIN_EN.
package sram_bridge_pkg;

   localparam int WAIT_W = 4;
   localparam int ID_W   = 3;

   localparam logic       CE_N_OFF = 1'b1;
   localparam logic       OE_N_OFF = 1'b1;
   localparam logic       WE_N_OFF = 1'b1;
   localparam logic [3:0] BE_N_OFF = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR_SETUP,
      ST_WR_PULSE,
      ST_WR_HOLD
   } state_t;

   function automatic logic [ID_W-1:0] onehot_to_id(input logic [7:0] oh);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) id = id | ID_W'(i);
      end
      return id;
   endfunction

endpackage

// File: rtl/sram_multiport_bridge_if.sv
// Requester-side bundle of the SRAM bridge: per-port request/ready plus shared response.
// master = CPU-side requesters, slave = bridge.
interface sram_multiport_bridge_if #(
   parameter int N_PORTS = 2
) ();
   logic [N_PORTS-1:0]    req_valid;
   logic [N_PORTS-1:0]    req_ready;
   logic [4*N_PORTS-1:0]  req_we;
   logic [32*N_PORTS-1:0] req_addr;
   logic [32*N_PORTS-1:0] req_wdata;
   logic [N_PORTS-1:0]    resp_valid;
   logic [31:0]           resp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/sram_arb_grant.sv
// One-hot grant from a request vector; lowest index wins, or round-robin from a pointer
// when SRAM_ARB_ROUND_ROBIN_EN is defined (pointer advances only on accept).
module sram_arb_grant
   import sram_bridge_pkg::*;
#(
   parameter int N_PORTS = 2
) (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic               clk,
   input  logic               reset,
   input  logic               i_accept,
`endif
   input  logic [N_PORTS-1:0] i_req,
   output logic [N_PORTS-1:0] o_grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0]    r_ptr;
   logic [N_PORTS-1:0] w_rot;
   logic [N_PORTS-1:0] w_pick;
   logic [ID_W-1:0]    w_gid;

   // Rotate so the pointer position sits at bit 0, pick lowest, rotate back.
   assign w_rot   = N_PORTS'({i_req, i_req} >> r_ptr);
   assign w_pick  = w_rot & (~w_rot + N_PORTS'(1));
   assign o_grant = N_PORTS'(({w_pick, w_pick} << r_ptr) >> N_PORTS);
   assign w_gid   = onehot_to_id(8'(o_grant));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_accept) begin
         r_ptr <= (w_gid == ID_W'(N_PORTS - 1)) ? '0 : w_gid + ID_W'(1);
      end
   end
`else
   assign o_grant = i_req & (~i_req + N_PORTS'(1));
`endif

endmodule

// File: rtl/sram_multiport_bridge.sv
// N-port to single async SRAM bridge with wait-state FSM; one transaction outstanding.
// Arbitration mode selected by SRAM_ARB_ROUND_ROBIN_EN (fixed priority when undefined).
module sram_multiport_bridge
   import sram_bridge_pkg::*;
#(
   parameter int N_PORTS = 2,
   parameter int ADDR_W  = 20,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   sram_multiport_bridge_if.slave bus,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [31:0]           ram_dq_o,
   output logic                  ram_dq_oe,
   input  logic [31:0]           ram_dq_i,
   output logic [3:0]            ram_be_n,
   output logic                  ram_ce_n,
   output logic                  ram_oe_n,
   output logic                  ram_we_n
);

   state_t              r_state;
   logic [WAIT_W-1:0]   r_cnt;
   logic [N_PORTS-1:0]  r_id_oh;
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [31:0]         r_ram_dq_o;
   logic                r_dq_oe;
   logic [3:0]          r_be_n;
   logic                r_ce_n;
   logic                r_oe_n;
   logic                r_we_n;
   logic [N_PORTS-1:0]  r_resp_valid;
   logic [31:0]         r_resp_rdata;

   logic [N_PORTS-1:0]  w_grant;
   logic [N_PORTS-1:0]  w_ready;
   logic                w_accept;
   logic [31:0]         w_sel_addr;
   logic [31:0]         w_sel_wdata;
   logic [3:0]          w_sel_we;
   logic                w_unused_addr;

   sram_arb_grant #(.N_PORTS(N_PORTS)) u_arb (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      .clk      (clk),
      .reset    (reset),
      .i_accept (w_accept),
`endif
      .i_req    (bus.req_valid),
      .o_grant  (w_grant)
   );

   assign w_ready       = (r_state == ST_IDLE) ? w_grant : '0;
   assign w_accept      = |(bus.req_valid & w_ready);
   assign w_unused_addr = ^w_sel_addr;

   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_we    = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (w_grant[i]) begin
            w_sel_addr  = bus.req_addr[32*i +: 32];
            w_sel_wdata = bus.req_wdata[32*i +: 32];
            w_sel_we    = bus.req_we[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_id_oh      <= '0;
         r_ram_addr   <= '0;
         r_ram_dq_o   <= '0;
         r_dq_oe      <= 1'b0;
         r_be_n       <= BE_N_OFF;
         r_ce_n       <= CE_N_OFF;
         r_oe_n       <= OE_N_OFF;
         r_we_n       <= WE_N_OFF;
         r_resp_valid <= '0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= '0;
         case (r_state)
            ST_IDLE: begin
               // Chip select stays low through the response cycle so back-to-back
               // transactions never glitch it high.
               r_ce_n <= w_accept ? 1'b0 : CE_N_OFF;
               if (w_accept) begin
                  r_id_oh    <= w_ready;
                  r_ram_addr <= w_sel_addr[ADDR_W+1:2];
                  if (w_sel_we == 4'h0) begin
                     r_state <= ST_RD;
                     r_oe_n  <= 1'b0;
                     r_be_n  <= 4'h0;
                     r_dq_oe <= 1'b0;
                     r_cnt   <= WAIT_W'(RD_WAIT);
                  end else begin
                     r_state    <= ST_WR_SETUP;
                     r_ram_dq_o <= w_sel_wdata;
                     r_dq_oe    <= 1'b1;
                     r_be_n     <= ~w_sel_we;
                  end
               end
            end
            ST_RD: begin
               if (r_cnt == '0) begin
                  r_state      <= ST_IDLE;
                  r_oe_n       <= OE_N_OFF;
                  r_be_n       <= BE_N_OFF;
                  r_resp_rdata <= ram_dq_i;
                  r_resp_valid <= r_id_oh;
               end else begin
                  r_cnt <= r_cnt - WAIT_W'(1);
               end
            end
            ST_WR_SETUP: begin
               r_state <= ST_WR_PULSE;
               r_we_n  <= 1'b0;
               r_cnt   <= WAIT_W'(WR_WAIT);
            end
            ST_WR_PULSE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_WR_HOLD;
                  r_we_n  <= WE_N_OFF;
               end else begin
                  r_cnt <= r_cnt - WAIT_W'(1);
               end
            end
            ST_WR_HOLD: begin
               r_state      <= ST_IDLE;
               r_dq_oe      <= 1'b0;
               r_be_n       <= BE_N_OFF;
               r_resp_valid <= r_id_oh;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = w_ready;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_rdata = r_resp_rdata;
   assign ram_addr       = r_ram_addr;
   assign ram_dq_o       = r_ram_dq_o;
   assign ram_dq_oe      = r_dq_oe;
   assign ram_be_n       = r_be_n;
   assign ram_ce_n       = r_ce_n;
   assign ram_oe_n       = r_oe_n;
   assign ram_we_n       = r_we_n;

endmodule
